// File: rtl/axi_stream_pkg.sv
// Shared constants and types for the AXI4-Stream video blocks.
//   AXIS_TDATA_WIDTH_* : common pixel beat widths
//   IMG_HEIGHT_MAX     : largest frame height (lines) any block must count to
//   arb_state_e        : frame arbiter FSM states
package axi_stream_pkg;

    localparam int AXIS_TDATA_WIDTH_8  = 8;
    localparam int AXIS_TDATA_WIDTH_24 = 24;
    localparam int AXIS_TDATA_WIDTH_32 = 32;

    localparam int IMG_HEIGHT_MAX = 1080;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req     : request vector, one bit per source
//   i_last    : index of the previously served source
//   o_gnt_oh  : one-hot winner (zero when no request)
//   o_gnt_idx : winner index
//   o_gnt_vld : at least one request present
// Search starts at (i_last+1) mod NUM_SRC and wraps.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IW = $clog2(NUM_SRC)
)(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_SRC-1:0] o_gnt_oh,
    output logic [IW-1:0]      o_gnt_idx,
    output logic               o_gnt_vld
);

    logic [NUM_SRC-1:0] w_rot;
    logic [IW:0]        w_off;
    logic [IW:0]        w_sum;

    always_comb begin
        // Rotate so bit 0 is the source right after the last winner.
        w_rot = NUM_SRC'({i_req, i_req} >> ({1'b0, i_last} + 1'b1));
        w_off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = (IW+1)'(k);
        end
        w_sum = {1'b0, i_last} + w_off + 1'b1;
        if (w_sum >= (IW+1)'(NUM_SRC)) w_sum = w_sum - (IW+1)'(NUM_SRC);
        o_gnt_vld = |i_req;
        o_gnt_idx = w_sum[IW-1:0];
        o_gnt_oh  = o_gnt_vld ? (NUM_SRC'(1) << w_sum[IW-1:0]) : '0;
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular AXI4-Stream video arbiter. Picks one source at its
// start-of-frame beat and passes it through unbuffered until cfg_height
// lines have been forwarded, then re-arbitrates round robin.
//   aclk, areset          : clock, async active-high reset
//   cfg_height            : lines per frame, latched at grant (0 -> 1)
//   s_axis_*              : NUM_SRC packed slave streams (tuser = SOF)
//   m_axis_*              : single master stream
//   grant_id              : current / last granted source
//   busy                  : a frame is being streamed
//   frame_done, frame_err : one-cycle status pulses
module axis_frame_arbiter
    import axi_stream_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH_24,
    parameter int MAX_LINES   = IMG_HEIGHT_MAX,
    localparam int HW = $clog2(MAX_LINES + 1),
    localparam int IW = $clog2(NUM_SRC)
)(
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [HW-1:0]                  cfg_height,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    input  logic [NUM_SRC-1:0]             s_axis_tuser,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [IW-1:0]                  grant_id,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           frame_err
);

    arb_state_e         r_state;
    logic [IW-1:0]      r_grant;
    logic [NUM_SRC-1:0] r_grant_oh;
    logic [IW-1:0]      r_last_grant;
    logic [HW-1:0]      r_height;
    logic [HW-1:0]      r_line_cnt;
    logic               r_first;
    logic               r_frame_done;
    logic               r_frame_err;

    logic [NUM_SRC-1:0] w_sof_req;
    logic [NUM_SRC-1:0] w_rr_oh;
    logic [IW-1:0]      w_rr_idx;
    logic               w_rr_vld;
    logic               w_stream;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;
    logic               w_accept;
    logic               w_sof_err;
    logic               w_frame_end;
    logic [HW-1:0]      w_line_next;
    logic [HW-1:0]      w_cfg_height;

    assign w_sof_req = s_axis_tvalid & s_axis_tuser;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .i_req     (w_sof_req),
        .i_last    (r_last_grant),
        .o_gnt_oh  (w_rr_oh),
        .o_gnt_idx (w_rr_idx),
        .o_gnt_vld (w_rr_vld)
    );

    assign w_stream    = (r_state == ST_STREAM);
    assign w_sel_valid = s_axis_tvalid[r_grant];
    assign w_sel_last  = s_axis_tlast[r_grant];
    assign w_sel_user  = s_axis_tuser[r_grant];
    assign w_accept    = w_stream & w_sel_valid & m_axis_tready;
    // A SOF after the first accepted beat means the source restarted a frame.
    assign w_sof_err   = w_accept & w_sel_user & ~r_first;

    always_comb begin
        w_line_next = w_sof_err ? '0 : r_line_cnt;
        if (w_sel_last) w_line_next = w_line_next + HW'(1);
    end

    // Counter only ever reaches r_height <= MAX_LINES, so it cannot wrap.
    assign w_frame_end = w_accept & w_sel_last & (w_line_next == r_height);

    always_comb begin
        if (cfg_height == '0)                 w_cfg_height = HW'(1);
        else if (cfg_height > HW'(MAX_LINES)) w_cfg_height = HW'(MAX_LINES);
        else                                  w_cfg_height = cfg_height;
    end

    // Datapath is pure muxing; reset gates the handshake outputs directly.
    assign m_axis_tdata  = s_axis_tdata[r_grant*TDATA_WIDTH +: TDATA_WIDTH];
    assign m_axis_tlast  = w_sel_last;
    assign m_axis_tuser  = w_sel_user;
    assign m_axis_tvalid = ~areset & w_stream & w_sel_valid;

    // IDLE drains stale mid-frame beats but holds SOF beats for arbitration.
    assign s_axis_tready = areset   ? '0 :
                           w_stream ? (r_grant_oh & {NUM_SRC{m_axis_tready}}) :
                                      (s_axis_tvalid & ~s_axis_tuser);

    assign grant_id   = r_grant;
    assign busy       = w_stream;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_grant_oh   <= NUM_SRC'(1);
            r_last_grant <= IW'(NUM_SRC - 1);
            r_height     <= HW'(1);
            r_line_cnt   <= '0;
            r_first      <= 1'b1;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_rr_vld) begin
                    r_grant    <= w_rr_idx;
                    r_grant_oh <= w_rr_oh;
                    r_height   <= w_cfg_height;
                    r_line_cnt <= '0;
                    r_first    <= 1'b1;
                    r_state    <= ST_STREAM;
                end
            end else if (w_accept) begin
                r_first     <= 1'b0;
                r_frame_err <= w_sof_err;
                r_line_cnt  <= w_line_next;
                if (w_frame_end) begin
                    r_frame_done <= 1'b1;
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomized bench for axis_frame_arbiter with a frame-level reference model.
module tb_axis_frame_arbiter;
    import axi_stream_pkg::*;

    localparam int N  = 4;
    localparam int DW = AXIS_TDATA_WIDTH_24;
    localparam int ML = IMG_HEIGHT_MAX;
    localparam int HW = $clog2(ML + 1);
    localparam int IW = $clog2(N);

    logic              aclk = 1'b0;
    logic              areset;
    logic [HW-1:0]     cfg_height;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [IW-1:0]     grant_id;
    logic              busy, frame_done, frame_err;

    axis_frame_arbiter #(.NUM_SRC(N), .TDATA_WIDTH(DW), .MAX_LINES(ML)) dut (
        .aclk(aclk), .areset(areset), .cfg_height(cfg_height),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-source beat queues: {user, last, data}
    logic [DW+1:0] srcq [N][$];
    int seq = 0;

    // Reference model state (frame-level view of the arbiter)
    bit m_in, m_first, m_done_q, m_err_q;
    int m_gnt, m_last, m_height, m_lines;

    int pvalid, pready;
    logic [HW-1:0] scen_h;
    int out_beats, n_done, n_err, n_flush;
    int dut_grants[$];
    bit prev_busy;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic add_frame(input int s, input int lines, input int bpl, input int err_beat);
        for (int b = 0; b < lines * bpl; b++) begin
            logic [DW+1:0] bt;
            bt[DW-1:0] = {4'(s), 20'(seq)};
            seq++;
            bt[DW]   = ((b % bpl) == bpl - 1);
            bt[DW+1] = (b == 0) || (b == err_beat);
            srcq[s].push_back(bt);
        end
    endtask

    task automatic add_stale(input int s, input int n);
        for (int b = 0; b < n; b++) begin
            logic [DW+1:0] bt;
            bt[DW-1:0] = {4'(s), 20'(seq)};
            seq++;
            bt[DW]   = 1'($urandom_range(1));
            bt[DW+1] = 1'b0;
            srcq[s].push_back(bt);
        end
    endtask

    task automatic clr_stats();
        out_beats = 0; n_done = 0; n_err = 0; n_flush = 0;
        dut_grants.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) < 32'(pvalid)) begin
                logic [DW+1:0] bt;
                bt = srcq[i][0];
                s_axis_tvalid[i] = 1'b1;
                s_axis_tuser[i]  = bt[DW+1];
                s_axis_tlast[i]  = bt[DW];
                s_axis_tdata[i*DW +: DW] = bt[DW-1:0];
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tuser[i]  = 1'($urandom_range(1));
                s_axis_tlast[i]  = 1'($urandom_range(1));
                s_axis_tdata[i*DW +: DW] = DW'($urandom);
            end
        end
        m_axis_tready = ($urandom_range(99) < 32'(pready));
        // Height must only matter at grant time; scramble it mid-frame.
        cfg_height = m_in ? HW'($urandom) : scen_h;
    endtask

    task automatic sample();
        logic [N-1:0] exp_rdy;
        bit nd, ne;
        exp_rdy = '0; nd = 0; ne = 0;
        chk("busy", 32'(busy), 32'(m_in));
        chk("frame_done", 32'(frame_done), 32'(m_done_q));
        chk("frame_err", 32'(frame_err), 32'(m_err_q));
        chk("grant_id", 32'(grant_id), 32'(m_gnt));
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
        prev_busy = busy;
        if (!m_in) begin
            logic [N-1:0] sof;
            chk("m_tvalid_idle", 32'(m_axis_tvalid), 32'(0));
            exp_rdy = s_axis_tvalid & ~s_axis_tuser;
            sof = s_axis_tvalid & s_axis_tuser;
            if (|sof) begin
                m_gnt    = rr_pick(sof, m_last);
                m_height = (cfg_height == 0) ? 1 : ((int'(cfg_height) > ML) ? ML : int'(cfg_height));
                m_lines  = 0;
                m_first  = 1;
                m_in     = 1;
            end
        end else begin
            int g;
            g = m_gnt;
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(s_axis_tvalid[g]));
            if (s_axis_tvalid[g]) begin
                chk("m_tdata", 32'(m_axis_tdata), 32'(s_axis_tdata[g*DW +: DW]));
                chk("m_tlast", 32'(m_axis_tlast), 32'(s_axis_tlast[g]));
                chk("m_tuser", 32'(m_axis_tuser), 32'(s_axis_tuser[g]));
            end
            exp_rdy[g] = m_axis_tready;
            if (s_axis_tvalid[g] && m_axis_tready) begin
                if (s_axis_tuser[g] && !m_first) begin
                    ne = 1;
                    m_lines = 0;
                end
                m_first = 0;
                if (s_axis_tlast[g]) begin
                    m_lines++;
                    if (m_lines == m_height) begin
                        m_in   = 0;
                        m_last = g;
                        nd     = 1;
                    end
                end
            end
        end
        chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                if (!busy && !s_axis_tuser[i]) n_flush++;
                void'(srcq[i].pop_front());
            end
        end
        if (m_axis_tvalid && m_axis_tready) out_beats++;
        m_done_q = nd;
        m_err_q  = ne;
    endtask

    task automatic cycle();
        drive();
        #4;
        sample();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = m_in || m_done_q || m_err_q;
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (pending() && cyc < budget) begin
            cycle();
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < budget), 32'(1));
        cycle();
        cycle();
    endtask

    task automatic model_reset();
        m_in = 0; m_first = 1; m_done_q = 0; m_err_q = 0;
        m_gnt = 0; m_last = N - 1; m_height = 1; m_lines = 0;
        prev_busy = 0;
        for (int i = 0; i < N; i++) srcq[i].delete();
    endtask

    initial begin
        int exp_beats, exp_frames, cyc;
        areset = 1'b1;
        s_axis_tvalid = '1; s_axis_tuser = '0; s_axis_tlast = '0;
        s_axis_tdata = '0; m_axis_tready = 1'b1; cfg_height = HW'(1);
        pvalid = 100; pready = 100; scen_h = HW'(1);
        model_reset();
        clr_stats();
        #2;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tready", 32'(s_axis_tready), 32'(0));
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        chk("rst_done", 32'(frame_done), 32'(0));
        chk("rst_err", 32'(frame_err), 32'(0));
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        s_axis_tvalid = '0;

        // Three sources holding SOF: strict rotation 0,1,2,0
        scen_h = HW'(2);
        add_frame(0, 2, 3, -1); add_frame(1, 2, 3, -1);
        add_frame(2, 2, 3, -1); add_frame(0, 2, 3, -1);
        run_drain("rr", 400);
        chk("rr_ngrants", 32'(dut_grants.size()), 32'(4));
        if (dut_grants.size() == 4) begin
            chk("rr_g0", 32'(dut_grants[0]), 32'(0));
            chk("rr_g1", 32'(dut_grants[1]), 32'(1));
            chk("rr_g2", 32'(dut_grants[2]), 32'(2));
            chk("rr_g3", 32'(dut_grants[3]), 32'(0));
        end
        chk("rr_done", 32'(n_done), 32'(4));

        // Single source, 4 lines x 8 beats
        clr_stats(); scen_h = HW'(4);
        add_frame(0, 4, 8, -1);
        run_drain("single", 400);
        chk("single_beats", 32'(out_beats), 32'(32));
        chk("single_done", 32'(n_done), 32'(1));
        chk("single_gnt", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'(0));

        // Stale non-SOF beats ahead of a frame are flushed
        clr_stats(); scen_h = HW'(2);
        add_stale(1, 3); add_frame(1, 2, 4, -1);
        run_drain("flush", 400);
        chk("flush_cnt", 32'(n_flush), 32'(3));
        chk("flush_beats", 32'(out_beats), 32'(8));
        chk("flush_done", 32'(n_done), 32'(1));

        // Downstream backpressure
        clr_stats(); scen_h = HW'(3); pready = 50; pvalid = 80;
        add_frame(2, 3, 5, -1);
        run_drain("bp", 600);
        chk("bp_beats", 32'(out_beats), 32'(15));
        chk("bp_done", 32'(n_done), 32'(1));

        // SOF on beat 10 restarts the line count
        clr_stats(); scen_h = HW'(3); pready = 100; pvalid = 100;
        add_frame(0, 4, 8, 10);
        run_drain("sof_err", 400);
        chk("sof_err_cnt", 32'(n_err), 32'(1));
        chk("sof_err_done", 32'(n_done), 32'(1));
        chk("sof_err_beats", 32'(out_beats), 32'(32));

        // Random mixes
        for (int r = 0; r < 6; r++) begin
            clr_stats();
            exp_beats = 0; exp_frames = 0;
            scen_h = HW'($urandom_range(3, 1));
            pvalid = $urandom_range(100, 60);
            pready = $urandom_range(100, 50);
            for (int s = 0; s < N; s++) begin
                int nf;
                nf = $urandom_range(2);
                for (int f = 0; f < nf; f++) begin
                    int bpl;
                    bpl = $urandom_range(4, 1);
                    add_stale(s, $urandom_range(2));
                    add_frame(s, int'(scen_h), bpl, -1);
                    exp_beats += int'(scen_h) * bpl;
                    exp_frames++;
                end
            end
            run_drain("rand", 3000);
            chk("rand_beats", 32'(out_beats), 32'(exp_beats));
            chk("rand_done", 32'(n_done), 32'(exp_frames));
        end

        // Async reset after line 1 of 4
        clr_stats(); scen_h = HW'(4); pvalid = 100; pready = 100;
        add_frame(3, 4, 4, -1);
        cyc = 0;
        while (!(m_in && m_lines == 1) && cyc < 200) begin
            cycle();
            cyc++;
        end
        chk("arst_reach", 32'(cyc < 200), 32'(1));
        drive();
        #2;
        areset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_tready", 32'(s_axis_tready), 32'(0));
        chk("arst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("arst_grant", 32'(grant_id), 32'(0));
        for (int k = 0; k < 2; k++) begin
            @(posedge aclk);
            #2;
            chk("arst_no_done", 32'(frame_done), 32'(0));
            chk("arst_busy_hold", 32'(busy), 32'(0));
        end
        @(posedge aclk);
        #1;
        model_reset();
        clr_stats();
        s_axis_tvalid = '0;
        areset = 1'b0;
        scen_h = HW'(1);
        add_frame(2, 1, 2, -1); add_frame(0, 1, 2, -1);
        run_drain("post_rst", 200);
        chk("post_rst_ngr", 32'(dut_grants.size()), 32'(2));
        if (dut_grants.size() > 0) chk("post_rst_g0", 32'(dut_grants[0]), 32'(0));
        chk("post_rst_done", 32'(n_done), 32'(2));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
